// File: rtl/cart_bus_if.sv
// cart_bus_if -- Atari cartridge-slot bus plus cartridge ROM port.
//
// Groups the signals the cartridge controller exchanges with the console
// slot (address, data, phase 2, R/W, MARIA halt, tristate and level-shifter
// controls) and with the ROM (address out, data in).
//
//   slave  : the cartridge controller side (samples the slot, drives ROM address,
//            data-out, tristate and level-shifter controls)
//   master : the console / ROM side (drives the slot and ROM data)
//
// Parameter BANK_BITS sizes mem_addr (14 + BANK_BITS bits) and must match
// the controller instance it is connected to.
interface cart_bus_if #(
    parameter int BANK_BITS = 3
);
    logic [15:0]           a;
    logic [7:0]            d_in;
    logic                  phi2;
    logic                  rw;
    logic                  halt;
    logic [13+BANK_BITS:0] mem_addr;
    logic [7:0]            mem_data;
    logic [7:0]            d_out;
    logic                  d_oe;
    logic                  buf_dir;
    logic                  buf_oe;

    modport slave (
        input  a, d_in, phi2, rw, halt, mem_data,
        output mem_addr, d_out, d_oe, buf_dir, buf_oe
    );

    modport master (
        output a, d_in, phi2, rw, halt, mem_data,
        input  mem_addr, d_out, d_oe, buf_dir, buf_oe
    );
endinterface

// File: rtl/cart_bus_ctrl.sv
// cart_bus_ctrl -- Atari 7800 cartridge bus controller.
//
// Synchronizes the asynchronous slot signals into the clk domain, maps the
// upper 48 KB of the CPU address space onto banked ROM, drives read data back
// onto the slot, and turns CPU writes into either peripheral register strobes
// or bank-register updates. A write is captured while phase 2 is high and
// committed once, when phase 2 falls.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   bus         cart_bus_if.slave: a, d_in, phi2, rw, halt, mem_data in;
//               mem_addr, d_out, d_oe, buf_dir, buf_oe out
//   per_we      one-clk peripheral write strobe
//   per_sel     one-hot peripheral window select (PERIPH_CNT bits)
//   per_addr    peripheral register index (A[3:0])
//   per_wdata   peripheral write data
//   bank        current bank register ($8000-$BFFF window)
//   active      console activity flag
//
// Optional feature: define CART_ACTIVITY_EN to build the phase-2 activity
// detector; without it, active is tied to 0 and no counter exists.
module cart_bus_ctrl #(
    parameter int          BANK_BITS   = 3,
    parameter logic [11:0] PERIPH_BASE = 12'h045,
    parameter int          PERIPH_CNT  = 1,
    parameter int          SYNC_STAGES = 2,
    parameter logic [22:0] ACT_TIMEOUT = 23'h100000
) (
    input  logic                  clk,
    input  logic                  rst,
    cart_bus_if.slave             bus,
    output logic                  per_we,
    output logic [PERIPH_CNT-1:0] per_sel,
    output logic [3:0]            per_addr,
    output logic [7:0]            per_wdata,
    output logic [BANK_BITS-1:0]  bank,
    output logic                  active
);

    typedef enum logic [1:0] {IDLE, CPU, DMA} state_t;

    localparam logic [BANK_BITS-1:0] BANK_HI = '1;
    localparam logic [BANK_BITS-1:0] BANK_LO = BANK_HI - 1'b1;

    if (SYNC_STAGES < 1 || PERIPH_CNT < 1 || PERIPH_CNT > 4 || ACT_TIMEOUT == '0) begin : g_param_check
        $error("cart_bus_ctrl: illegal parameter value");
    end

    // One-hot hit vector of the peripheral windows for an address.
    function automatic logic [PERIPH_CNT-1:0] periph_dec(input logic [15:0] addr);
        logic [PERIPH_CNT-1:0] sel;
        sel = '0;
        for (int i = 0; i < PERIPH_CNT; i++)
            sel[i] = (addr[15:4] == (PERIPH_BASE + 12'(i)));
        return sel;
    endfunction

    function automatic logic bank_win(input logic [15:0] addr);
        return addr[15:14] == 2'b10;
    endfunction

    // ---------------- input synchronizers ----------------
    logic [15:0]            a_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] phi2_sync;
    logic [SYNC_STAGES-1:0] rw_sync;
    logic [SYNC_STAGES-1:0] halt_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                a_sync[i] <= '0;
            phi2_sync <= '0;
            rw_sync   <= '0;
            halt_sync <= '0;
        end else begin
            a_sync[0]    <= bus.a;
            phi2_sync[0] <= bus.phi2;
            rw_sync[0]   <= bus.rw;
            halt_sync[0] <= bus.halt;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sync[i]    <= a_sync[i-1];
                phi2_sync[i] <= phi2_sync[i-1];
                rw_sync[i]   <= rw_sync[i-1];
                halt_sync[i] <= halt_sync[i-1];
            end
        end
    end

    logic [15:0] a_s;
    logic        phi2_s;
    logic        rw_s;
    logic        halt_s;

    assign a_s    = a_sync[SYNC_STAGES-1];
    assign phi2_s = phi2_sync[SYNC_STAGES-1];
    assign rw_s   = rw_sync[SYNC_STAGES-1];
    assign halt_s = halt_sync[SYNC_STAGES-1];

    // ---------------- decode ----------------
    state_t                 state;
    logic                   wr_pend;
    logic [15:0]            wr_addr;
    logic [7:0]             wr_data;
    logic [PERIPH_CNT-1:0]  a_sel;
    logic [PERIPH_CNT-1:0]  wr_sel;
    logic                   wr_bank;
    logic                   d_oe_next;
    logic                   wr_hit;
    logic                   cpu_next;
    logic                   commit;
    logic [BANK_BITS-1:0]   bank_sel;

    assign a_sel   = periph_dec(a_s);
    assign wr_sel  = periph_dec(wr_addr);
    assign wr_bank = bank_win(wr_addr);

    assign d_oe_next = (a_s[15:14] != 2'b00) & rw_s & ((state == CPU) | (state == DMA));
    assign wr_hit    = ~rw_s & phi2_s & halt_s & ((|a_sel) | bank_win(a_s));

    // cpu_next: the FSM is in (or entering) CPU this clk, so a write sample is
    // taken even when phase 2 is high for a single clk.
    assign cpu_next = halt_s & phi2_s & (state != DMA);
    // Commit only on the CPU -> IDLE edge; a CPU -> DMA exit drops the write.
    assign commit   = (state == CPU) & halt_s & ~phi2_s & wr_pend;

    always_comb begin
        bank_sel = bank;
        case (a_s[15:14])
            2'b01:   bank_sel = BANK_LO;
            2'b10:   bank_sel = bank;
            2'b11:   bank_sel = BANK_HI;
            default: bank_sel = bank;
        endcase
    end

    // ---------------- ROM address / read data ----------------
    always_ff @(posedge clk)
        bus.mem_addr <= {bank_sel, a_s[13:0]};

    // ROM answers one clk after mem_addr, so data is valid two clks after a_s.
    assign bus.d_out = bus.mem_data;

    // Last sample of the write phase wins.
    always_ff @(posedge clk) begin
        if (cpu_next && !rw_s) begin
            wr_addr <= a_s;
            wr_data <= bus.d_in;
        end
    end

    // ---------------- bus FSM and registered outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_pend     <= 1'b0;
            bus.d_oe    <= 1'b0;
            bus.buf_oe  <= 1'b1;
            bus.buf_dir <= 1'b0;
            per_we      <= 1'b0;
            per_sel     <= '0;
            per_addr    <= '0;
            per_wdata   <= '0;
            bank        <= '0;
        end else begin
            bus.d_oe    <= d_oe_next;
            bus.buf_dir <= rw_s;
            bus.buf_oe  <= ~(d_oe_next | wr_hit);
            per_we      <= 1'b0;

            case (state)
                IDLE:    if (!halt_s) state <= DMA;
                         else if (phi2_s) state <= CPU;
                CPU:     if (!halt_s) state <= DMA;
                         else if (!phi2_s) state <= IDLE;
                DMA:     if (halt_s) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (!halt_s)
                wr_pend <= 1'b0;
            else if (cpu_next && !rw_s)
                wr_pend <= 1'b1;
            else if (commit)
                wr_pend <= 1'b0;

            if (commit) begin
                if ((|wr_sel) || wr_bank)
                    per_wdata <= wr_data;
                if (|wr_sel) begin
                    per_we   <= 1'b1;
                    per_sel  <= wr_sel;
                    per_addr <= wr_addr[3:0];
                end
                if (wr_bank)
                    bank <= wr_data[BANK_BITS-1:0];
            end
        end
    end

    // ---------------- activity detector ----------------
`ifdef CART_ACTIVITY_EN
    logic        phi2_prev;
    logic [22:0] act_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            phi2_prev <= 1'b0;
            act_cnt   <= '0;
            active    <= 1'b0;
        end else begin
            phi2_prev <= phi2_s;
            if (phi2_s != phi2_prev) begin
                active  <= 1'b1;
                act_cnt <= ACT_TIMEOUT;
            end else if (act_cnt != '0) begin
                act_cnt <= act_cnt - 1'b1;
            end else begin
                active  <= 1'b0;
            end
        end
    end
`else
    assign active = 1'b0;
`endif

endmodule
